// File: rtl/fft8_stream_ctrl.sv
// Streaming wrapper around a combinational 8-point FFT core: collects one frame of
// samples (zero-padding after an early s_last), captures the bins, then streams them out.
module fft8_stream_ctrl #(
    parameter int DATA_W = 8,
    parameter int NPT    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_real,
    input  logic [DATA_W-1:0]     s_imag,
    input  logic                  s_last,
    output logic [NPT*DATA_W-1:0] core_in_real,
    output logic [NPT*DATA_W-1:0] core_in_imag,
    input  logic [NPT*DATA_W-1:0] core_out_real,
    input  logic [NPT*DATA_W-1:0] core_out_imag,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_W-1:0]     m_real,
    output logic [DATA_W-1:0]     m_imag,
    output logic [2:0]            m_index,
    output logic                  m_last,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        CAPTURE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [2:0]        wr_idx;
    logic [2:0]        rd_idx;
    logic [DATA_W-1:0] in_re  [NPT];
    logic [DATA_W-1:0] in_im  [NPT];
    logic [DATA_W-1:0] out_re [NPT];
    logic [DATA_W-1:0] out_im [NPT];

    logic s_xfer;
    logic m_xfer;
    logic in_done;

    assign s_xfer  = (state == LOAD) && s_valid;
    assign m_xfer  = (state == UNLOAD) && m_ready;
    assign in_done = s_xfer && (s_last || (wr_idx == 3'(NPT - 1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (in_done) state_nx = CAPTURE;
            CAPTURE: state_nx = UNLOAD;
            UNLOAD:  if (m_xfer && (rd_idx == 3'(NPT - 1))) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_idx    <= '0;
            rd_idx    <= '0;
            frame_cnt <= '0;
            for (int unsigned i = 0; i < NPT; i++) begin
                in_re[i]  <= '0;
                in_im[i]  <= '0;
                out_re[i] <= '0;
                out_im[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (s_xfer) begin
                        // early s_last clears every slot above the one being written
                        for (int unsigned i = 0; i < NPT; i++) begin
                            if (3'(i) == wr_idx) begin
                                in_re[i] <= s_real;
                                in_im[i] <= s_imag;
                            end else if (s_last && (3'(i) > wr_idx)) begin
                                in_re[i] <= '0;
                                in_im[i] <= '0;
                            end
                        end
                        wr_idx <= wr_idx + 3'd1;
                    end
                end
                CAPTURE: begin
                    for (int unsigned i = 0; i < NPT; i++) begin
                        out_re[i] <= core_out_real[DATA_W*i +: DATA_W];
                        out_im[i] <= core_out_imag[DATA_W*i +: DATA_W];
                    end
                    wr_idx <= '0;
                end
                UNLOAD: begin
                    if (m_xfer) begin
                        if (rd_idx == 3'(NPT - 1)) begin
                            rd_idx    <= '0;
                            frame_cnt <= frame_cnt + 16'd1;
                        end else begin
                            rd_idx <= rd_idx + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        core_in_real = '0;
        core_in_imag = '0;
        for (int unsigned i = 0; i < NPT; i++) begin
            core_in_real[DATA_W*i +: DATA_W] = in_re[i];
            core_in_imag[DATA_W*i +: DATA_W] = in_im[i];
        end
    end

    assign s_ready = (state == LOAD);
    assign m_valid = (state == UNLOAD);
    assign m_real  = m_valid ? out_re[rd_idx] : '0;
    assign m_imag  = m_valid ? out_im[rd_idx] : '0;
    assign m_index = m_valid ? rd_idx : '0;
    assign m_last  = m_valid && (rd_idx == 3'(NPT - 1));
    assign busy    = !((state == LOAD) && (wr_idx == '0));

endmodule
